// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared adder-family package.
// Holds the controller state encoding, the ADD/SUB opcode encoding and
// the slice width used by the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bus of the nibble-serial adder controller.
// Request side : in_valid/in_ready handshake carrying A, B, Cin, Op.
// Result side  : out_valid/out_ready handshake carrying Sum, Cout, Ovf.
// Modports     : master = requester/consumer, slave = controller.
interface nibble_serial_add_ctrl_if
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = SLICE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Op;        // compared against op_t encodings
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  modport master (
    output in_valid, A, B, Cin, Op, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Op, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/full_adder_4bit_st.sv
// 4-bit ripple-carry adder slice.
// Ports: i_a, i_b (4-bit addends), i_cin (carry in),
//        o_sum (4-bit sum), o_cout (carry out of bit 3).
module full_adder_4bit_st (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_bit
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller.
// Accepts one request in IDLE, processes one 4-bit slice per cycle in RUN
// (NIBBLES cycles, LSB nibble first) and presents the result in DONE until
// the consumer takes it.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_valid/in_ready,
//        A, B, Cin, Op, out_valid/out_ready, Sum, Cout, Ovf).
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_add_ctrl_if.slave  bus
);
  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic               w_msb_cin;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_a_nib  = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_nib  = r_b[r_idx*SLICE_W +: SLICE_W];

  full_adder_4bit_st u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // The carry into the MSB is recovered from the MSB sum bit, so the slice
  // only needs to export its final carry.
  assign w_msb_cin = w_a_nib[SLICE_W-1] ^ w_b_nib[SLICE_W-1] ^ w_slice_sum[SLICE_W-1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_state_next = ST_RUN;
      ST_RUN:  if (w_last)        w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
            r_a     <= bus.A;
            r_b     <= (bus.Op == OP_SUB) ? ~bus.B : bus.B;
            r_carry <= (bus.Op == OP_SUB) ? 1'b1 : bus.Cin;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= w_slice_sum;
          r_carry                         <= w_slice_cout;
          if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= w_msb_cin ^ w_slice_cout;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.Sum       = r_sum;
  assign bus.Cout      = r_cout;
  assign bus.Ovf       = r_ovf;
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid input 1, request valid; in_ready output 1, controller can accept a request.
REQ-005 SHALL have ports: A input W, first operand; B input W, second operand; Cin input 1, carry-in (ADD only); Op input 1, 0=ADD, 1=SUB.
REQ-006 SHALL have ports: out_valid output 1, result valid; out_ready input 1, consumer accepts the result.
REQ-007 SHALL have ports: Sum output W, result; Cout output 1, final carry; Ovf output 1, signed overflow.

Function
REQ-008 SHALL implement FSM states IDLE, RUN, DONE.
REQ-009 in_ready SHALL be 1 only in IDLE.
REQ-010 out_valid SHALL be 1 only in DONE.
REQ-011 IDLE->RUN on in_valid&in_ready: capture A and B (B inverted when Op=1), carry register = (Op ? 1 : Cin), nibble index = 0.
REQ-012 RUN: each cycle, one 4-bit slice adds captured nibble[idx] of A and B with the carry register; the result writes Sum nibble idx and the slice carry-out updates the carry register.
REQ-013 RUN->DONE when idx = NIBBLES-1 is processed; otherwise idx increments by 1.
REQ-014 Latency SHALL be exactly NIBBLES cycles in RUN; out_valid rises NIBBLES cycles after the accepting edge.
REQ-015 DONE: Cout = final carry register; Ovf = carry into MSB XOR carry out of MSB, captured on the last RUN cycle.
REQ-016 Sum, Cout and Ovf SHALL hold stable while out_valid=1 && out_ready=0.
REQ-017 DONE->IDLE on out_ready=1; out_valid deasserts the following cycle.
REQ-018 Inputs A/B/Cin/Op SHALL be ignored outside the IDLE accept edge; changes during RUN have no effect.
REQ-019 in_valid during RUN or DONE SHALL NOT be accepted (in_ready=0); the requester holds it.
REQ-020 No back-to-back bypass: at least one IDLE cycle between results; throughput is one result per NIBBLES+2 cycles minimum.
REQ-021 SUB SHALL compute A-B mod 2^W; Cout=1 means no borrow.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, idx=0, carry register=0, Sum=0, Cout=0, Ovf=0, out_valid=0, in_ready=1, regardless of clock.
REQ-023 Reset asserted mid-RUN or in DONE SHALL discard the operation; no partial result is presented after release.
REQ-024 After rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Structure
REQ-025 State encoding and Op encodings (ADD/SUB) SHALL be defined as constants in the shared adder package used by the adder-family modules.
REQ-026 The slice SHALL be one instance of the existing 4-bit ripple adder full_adder_4bit_st; no other sub-modules.
REQ-027 The nibble select/insert SHALL use idx-indexed part-selects; no per-nibble duplicated logic.

Verification
REQ-028 ADD A=16'h1234, B=16'h1111, Cin=0, Op=0 -> out_valid 4 cycles after accept; Sum=16'h2345, Cout=0, Ovf=0.
REQ-029 ADD A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1, Ovf=0; ADD A=16'h7FFF, B=16'h0001 -> Sum=16'h8000, Ovf=1.
REQ-030 SUB A=16'h0005, B=16'h0007 -> Sum=16'hFFFE, Cout=0; SUB A=16'h8000, B=16'h0001 -> Sum=16'h7FFF, Ovf=1.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> Sum/Cout/Ovf stable, in_ready=0 throughout, and a second in_valid is not accepted until DONE->IDLE.
REQ-032 Mid-operation change and reset: change A/B during RUN -> result is unaffected; assert rst_n=0 at RUN idx=2 -> all outputs 0 and in_ready=1 immediately, and no out_valid after release.
